// File: rtl/dsp_op_scheduler_pkg.sv
// Shared mode encodings, pass-count helper and FSM state type for the
// DSP operation scheduler.
package dsp_op_scheduler_pkg;

   localparam logic [1:0] MODE_HH  = 2'd0;
   localparam logic [1:0] MODE_HF  = 2'd1;
   localparam logic [1:0] MODE_FF  = 2'd2;
   localparam logic [1:0] MODE_ILL = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_CAPT = 2'd3
   } state_t;

   // Number of partial-product passes the DSP needs for a given mode.
   function automatic logic [2:0] passes(input logic [1:0] mode);
      case (mode)
         MODE_HH: passes = 3'd1;
         MODE_HF: passes = 3'd2;
         default: passes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/dsp_op_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the requester not served last wins.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] i_req,
   input  logic       i_advance,
   output logic [1:0] o_grant
);

   logic r_prio;

   // Grant the lone requester, or the priority holder on a tie.
   always_comb begin
      o_grant = i_req;
      if (i_req == 2'b11) begin
         o_grant = r_prio ? 2'b10 : 2'b01;
      end
   end

   // After a served grant, priority moves to the other requester.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prio <= 1'b0;
      end else if (i_advance) begin
         r_prio <= ~o_grant[1];
      end
   end

endmodule

// File: rtl/dsp_op_scheduler.sv
// Sequences the fused multiply/add DSP for two requesters and buffers one
// result. Outside RUN all DSP operands are zero so the DSP sum holds.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting for a request; illegal modes answered from here
//   ST_ARM  | one neutral cycle, dsp_mac primes the DSP accumulate flag
//   ST_RUN  | P passes with operands held, start on the first pass only
//   ST_CAPT | one neutral cycle, dsp_out captured into the response buffer
module dsp_op_scheduler
   import dsp_op_scheduler_pkg::*;
#(
   parameter int N                = 33,
   parameter int SHIFT_BITS       = 2,
   parameter int PIPE_STAGES_BITS = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  req_valid,
   output logic [1:0]                  req_ready,
   input  logic [2*N-1:0]              req_a,
   input  logic [2*N-1:0]              req_b,
   input  logic [4*N-1:0]              req_c,
   input  logic [3:0]                  req_mode,
   input  logic [1:0]                  req_acc,
   input  logic [2*SHIFT_BITS-1:0]     req_shamt,
   input  logic [1:0]                  req_shdir,
   output logic                        resp_valid,
   input  logic                        resp_ready,
   output logic [2*N-1:0]              resp_data,
   output logic                        resp_id,
   output logic                        resp_err,
   output logic                        dsp_start,
   output logic                        dsp_mac,
   output logic                        dsp_shift_dir,
   output logic [1:0]                  dsp_mode,
   output logic [SHIFT_BITS-1:0]       dsp_shift_amount,
   output logic [PIPE_STAGES_BITS-1:0] dsp_pipe_stages,
   output logic [N-1:0]                dsp_aa,
   output logic [N-1:0]                dsp_bb,
   output logic [2*N-1:0]              dsp_cc,
   input  logic [2*N-1:0]              dsp_out
);

   state_t                r_state, w_next;
   logic                  r_live;
   logic [2:0]            r_cnt;
   logic [N-1:0]          r_a, r_b;
   logic [2*N-1:0]        r_c;
   logic [1:0]            r_mode;
   logic                  r_acc_eff, r_id, r_err, r_shdir;
   logic [SHIFT_BITS-1:0] r_shamt;
   logic                  r_owner_valid, r_owner_id;
   logic                  r_resp_valid, r_resp_id, r_resp_err;
   logic [2*N-1:0]        r_resp_data;

   logic [1:0]            w_grant;
   logic                  w_gid, w_drain, w_accept, w_hs, w_first;
   logic [N-1:0]          w_a, w_b;
   logic [2*N-1:0]        w_c;
   logic [1:0]            w_mode;
   logic                  w_acc, w_acc_eff, w_ill, w_shdir;
   logic [SHIFT_BITS-1:0] w_shamt;

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req_valid),
      .i_advance (w_hs),
      .o_grant   (w_grant)
   );

   assign w_drain   = r_resp_valid & resp_ready;
   assign w_accept  = r_live & (r_state == ST_IDLE) & (~r_resp_valid | w_drain);
   assign req_ready = w_grant & {2{w_accept}};
   assign w_hs      = |(req_valid & req_ready);
   assign w_gid     = w_grant[1];

   assign w_a     = w_gid ? req_a[2*N-1:N]         : req_a[N-1:0];
   assign w_b     = w_gid ? req_b[2*N-1:N]         : req_b[N-1:0];
   assign w_c     = w_gid ? req_c[4*N-1:2*N]       : req_c[2*N-1:0];
   assign w_mode  = w_gid ? req_mode[3:2]          : req_mode[1:0];
   assign w_shamt = w_gid ? req_shamt[2*SHIFT_BITS-1:SHIFT_BITS] : req_shamt[SHIFT_BITS-1:0];
   assign w_shdir = w_gid ? req_shdir[1] : req_shdir[0];
   assign w_acc   = w_gid ? req_acc[1]   : req_acc[0];
   assign w_ill   = (w_mode == MODE_ILL);
   // Accumulating is only meaningful onto this requester's own last result.
   assign w_acc_eff = w_acc & r_owner_valid & (r_owner_id == w_gid);
   assign w_first   = (r_cnt == passes(r_mode));

   // Hold off req_ready until the first cycle after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_live <= 1'b0;
      else        r_live <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic; illegal modes never leave IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_hs && !w_ill) w_next = ST_ARM;
         ST_ARM:  w_next = ST_RUN;
         ST_RUN:  if (r_cnt == 3'd1) w_next = ST_CAPT;
         ST_CAPT: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // DSP control outputs; everything is neutral outside RUN except mac in ARM.
   always_comb begin
      dsp_start        = 1'b0;
      dsp_mac          = 1'b0;
      dsp_mode         = MODE_HH;
      dsp_aa           = '0;
      dsp_bb           = '0;
      dsp_cc           = '0;
      dsp_shift_amount = '0;
      dsp_shift_dir    = 1'b0;
      dsp_pipe_stages  = '0;
      case (r_state)
         ST_ARM: dsp_mac = r_acc_eff;
         ST_RUN: begin
            dsp_start        = w_first;
            dsp_mac          = r_acc_eff & w_first;
            dsp_mode         = r_mode;
            dsp_aa           = r_a;
            dsp_bb           = r_b;
            dsp_cc           = r_c;
            dsp_shift_amount = r_shamt;
            dsp_shift_dir    = r_shdir;
         end
         default: ;
      endcase
   end

   // Operation register and remaining-pass down-counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a       <= '0;
         r_b       <= '0;
         r_c       <= '0;
         r_mode    <= MODE_HH;
         r_acc_eff <= 1'b0;
         r_id      <= 1'b0;
         r_err     <= 1'b0;
         r_shamt   <= '0;
         r_shdir   <= 1'b0;
         r_cnt     <= '0;
      end else if (w_hs) begin
         r_a       <= w_a;
         r_b       <= w_b;
         r_c       <= w_c;
         r_mode    <= w_mode;
         r_acc_eff <= w_acc_eff;
         r_id      <= w_gid;
         r_err     <= w_acc & ~w_acc_eff;
         r_shamt   <= w_shamt;
         r_shdir   <= w_shdir;
         r_cnt     <= passes(w_mode);
      end else if (r_state == ST_RUN) begin
         r_cnt     <= r_cnt - 3'd1;
      end
   end

   // Response buffer and result ownership; a fill wins over a same-cycle drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_resp_valid  <= 1'b0;
         r_resp_data   <= '0;
         r_resp_id     <= 1'b0;
         r_resp_err    <= 1'b0;
         r_owner_valid <= 1'b0;
         r_owner_id    <= 1'b0;
      end else if (w_hs && w_ill) begin
         r_resp_valid  <= 1'b1;
         r_resp_data   <= '0;
         r_resp_id     <= w_gid;
         r_resp_err    <= 1'b1;
      end else if (r_state == ST_CAPT) begin
         r_resp_valid  <= 1'b1;
         r_resp_data   <= dsp_out;
         r_resp_id     <= r_id;
         r_resp_err    <= r_err;
         r_owner_valid <= 1'b1;
         r_owner_id    <= r_id;
      end else if (w_drain) begin
         r_resp_valid  <= 1'b0;
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_data  = r_resp_data;
   assign resp_id    = r_resp_id;
   assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_dsp_op_scheduler.sv
// Bench for dsp_op_scheduler: a DSP stand-in, an arithmetic reference model
// with a per-cycle compare process, and directed operations.
module tb_dsp_op_scheduler;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   req_valid, req_ready;
   logic [65:0]  req_a, req_b;
   logic [131:0] req_c;
   logic [3:0]   req_mode;
   logic [1:0]   req_acc, req_shdir;
   logic [3:0]   req_shamt;
   logic         resp_valid, resp_ready, resp_id, resp_err;
   logic [65:0]  resp_data;
   logic         dsp_start, dsp_mac, dsp_shift_dir;
   logic [1:0]   dsp_mode, dsp_shift_amount, dsp_pipe_stages;
   logic [32:0]  dsp_aa, dsp_bb;
   logic [65:0]  dsp_cc, dsp_out;

   always #5 clk = ~clk;

   dsp_op_scheduler dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_mode(req_mode),
      .req_acc(req_acc), .req_shamt(req_shamt), .req_shdir(req_shdir),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
      .resp_id(resp_id), .resp_err(resp_err), .dsp_start(dsp_start),
      .dsp_mac(dsp_mac), .dsp_shift_dir(dsp_shift_dir), .dsp_mode(dsp_mode),
      .dsp_shift_amount(dsp_shift_amount), .dsp_pipe_stages(dsp_pipe_stages),
      .dsp_aa(dsp_aa), .dsp_bb(dsp_bb), .dsp_cc(dsp_cc), .dsp_out(dsp_out)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_chk++;
      n_err++;
      $display("FAIL %s: event did not occur as required", name);
   endtask

   function automatic logic [65:0] acc_shift(input logic [65:0] v, input logic [1:0] s, input logic dir);
      acc_shift = dir ? (v >> s) : (v << s);
   endfunction

   // ---------------- DSP stand-in: one partial product per pass ----------------
   logic [65:0] dsp_sum = 66'h2_F00D_0000_1234_5678;
   logic        dsp_mac_prev;
   logic [2:0]  dsp_k;

   function automatic logic [65:0] pp(input logic [32:0] a, input logic [32:0] b,
                                      input logic [1:0] m, input logic [2:0] k);
      logic [65:0] al, ah, bl, bh;
      al = {49'd0, a[16:0]};
      ah = {50'd0, a[32:17]};
      bl = {49'd0, b[16:0]};
      bh = {50'd0, b[32:17]};
      case (k)
         3'd0:    pp = al * bl;
         3'd1:    pp = (m != 2'd0) ? ((al * bh) << 17) : 66'd0;
         3'd2:    pp = (m == 2'd2) ? ((ah * bl) << 17) : 66'd0;
         3'd3:    pp = (m == 2'd2) ? ((ah * bh) << 34) : 66'd0;
         default: pp = 66'd0;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dsp_mac_prev <= 1'b0;
         dsp_k        <= 3'd4;
      end else begin
         dsp_mac_prev <= dsp_mac;
         if (dsp_start) begin
            dsp_sum <= (dsp_mac_prev ? acc_shift(dsp_sum, dsp_shift_amount, dsp_shift_dir) : 66'd0)
                       + dsp_cc + pp(dsp_aa, dsp_bb, dsp_mode, 3'd0);
            dsp_k   <= 3'd1;
         end else begin
            dsp_sum <= dsp_sum + pp(dsp_aa, dsp_bb, dsp_mode, dsp_k);
            if (dsp_k != 3'd4) dsp_k <= dsp_k + 3'd1;
         end
      end
   end
   assign dsp_out = dsp_sum;

   // ---------------- reference model ----------------
   typedef struct {
      logic [65:0] data;
      logic        id;
      logic        err;
      int          t_hs;
      int          t_exp;
   } exp_t;

   exp_t        q[$];
   int          hs_ids[$];
   int          cyc = 0, hs_cnt = 0, resp_cnt = 0, n_start = 0, n_mac = 0;
   logic [65:0] last_data;
   logic        last_id, last_err;
   int          last_lat;
   bit          m_owner_valid = 0;
   int          m_owner_id = 0;
   logic [65:0] m_prev = '0;
   bit          prev_rv = 0, prev_drain = 0;

   bit          if_valid = 0, if_ill = 0, if_acc = 0, if_dir = 0;
   int          if_ths = 0, if_p = 1;
   logic [32:0] if_a, if_b;
   logic [65:0] if_c;
   logic [1:0]  if_mode, if_shamt;

   function automatic logic [65:0] ref_prod(input logic [32:0] a, input logic [32:0] b, input logic [1:0] m);
      logic [65:0] fa, fb, ha, hb;
      fa = {33'd0, a};
      fb = {33'd0, b};
      ha = {49'd0, a[16:0]};
      hb = {49'd0, b[16:0]};
      case (m)
         2'd0:    ref_prod = ha * hb;
         2'd1:    ref_prod = ha * fb;
         default: ref_prod = fa * fb;
      endcase
   endfunction

   function automatic int npass(input logic [1:0] m);
      case (m)
         2'd0:    npass = 1;
         2'd1:    npass = 2;
         default: npass = 4;
      endcase
   endfunction

   int          d;
   bit          in_run, e_start, e_mac;
   logic [32:0] e_aa, e_bb;
   logic [65:0] e_cc;
   logic [1:0]  e_mode;
   logic [32:0] m_a, m_b;
   logic [65:0] m_c;
   logic [1:0]  m_m, m_sh;
   bit          m_acc, m_dir, m_eff;
   exp_t        e, f;

   // Compare process: samples mid-cycle, checks DSP drive, buffer and responses.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         if_valid      = 0;
         m_owner_valid = 0;
         prev_rv       = 0;
         prev_drain    = 0;
         chk("rst_req_ready", req_ready, 0);
         chk("rst_resp_valid", resp_valid, 0);
         chk("rst_resp_data", resp_data, 0);
         chk("rst_dsp_start", dsp_start, 0);
         chk("rst_dsp_mac", dsp_mac, 0);
         chk("rst_dsp_aa", dsp_aa, 0);
         chk("rst_dsp_cc", dsp_cc, 0);
      end else begin
         cyc++;
         d = cyc - if_ths;
         in_run = 0; e_start = 0; e_mac = 0;
         e_aa = '0; e_bb = '0; e_cc = '0; e_mode = '0;
         if (if_valid && !if_ill) begin
            if (d == 1) e_mac = if_acc;
            else if (d >= 2 && d <= if_p + 1) begin
               in_run  = 1;
               e_start = (d == 2);
               e_mac   = if_acc && (d == 2);
               e_aa = if_a; e_bb = if_b; e_cc = if_c; e_mode = if_mode;
            end
         end
         chk("dsp_start", dsp_start, e_start);
         chk("dsp_mac", dsp_mac, e_mac);
         chk("dsp_aa", dsp_aa, e_aa);
         chk("dsp_bb", dsp_bb, e_bb);
         chk("dsp_cc", dsp_cc, e_cc);
         chk("dsp_mode", dsp_mode, e_mode);
         chk("dsp_pipe_stages", dsp_pipe_stages, 0);
         if (in_run) begin
            chk("dsp_shift_amount", dsp_shift_amount, if_shamt);
            chk("dsp_shift_dir", dsp_shift_dir, if_dir);
         end
         if (dsp_start) n_start++;
         if (dsp_mac) n_mac++;
         chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
         if (resp_valid && !resp_ready) chk("full_no_accept", req_ready, 0);

         if (resp_valid && (!prev_rv || prev_drain)) begin
            if (q.size() == 0) fail_now("resp_unexpected");
            else begin
               chk("resp_latency", cyc, q[0].t_exp);
               last_lat = cyc - q[0].t_hs;
            end
         end
         if (resp_valid && resp_ready) begin
            if (q.size() == 0) fail_now("resp_unexpected_drain");
            else begin
               f = q.pop_front();
               chk("resp_data", resp_data, f.data);
               chk("resp_id", resp_id, f.id);
               chk("resp_err", resp_err, f.err);
               last_data = resp_data; last_id = resp_id; last_err = resp_err;
               resp_cnt++;
            end
         end
         prev_rv    = resp_valid;
         prev_drain = resp_valid && resp_ready;

         for (int i = 0; i < 2; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               m_a   = req_a[i*33 +: 33];
               m_b   = req_b[i*33 +: 33];
               m_c   = req_c[i*66 +: 66];
               m_m   = req_mode[i*2 +: 2];
               m_sh  = req_shamt[i*2 +: 2];
               m_acc = req_acc[i];
               m_dir = req_shdir[i];
               e.id = i[0]; e.t_hs = cyc;
               if (m_m == 2'd3) begin
                  e.data = '0; e.err = 1; e.t_exp = cyc + 1;
                  if_ill = 1;
               end else begin
                  m_eff  = m_acc && m_owner_valid && (m_owner_id == i);
                  e.data = (m_eff ? acc_shift(m_prev, m_sh, m_dir) : 66'd0) + m_c + ref_prod(m_a, m_b, m_m);
                  e.err  = m_acc && !m_eff;
                  e.t_exp = cyc + npass(m_m) + 3;
                  m_prev = e.data; m_owner_valid = 1; m_owner_id = i;
                  if_ill = 0; if_acc = m_eff; if_p = npass(m_m);
                  if_a = m_a; if_b = m_b; if_c = m_c; if_mode = m_m;
                  if_shamt = m_sh; if_dir = m_dir;
               end
               if_valid = 1; if_ths = cyc;
               q.push_back(e);
               hs_cnt++;
               hs_ids.push_back(i);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_req(input int id, input logic [1:0] mode, input logic [32:0] a, input logic [32:0] b,
                          input logic [65:0] c, input logic acc, input logic [1:0] shamt, input logic dir);
      req_a[id*33 +: 33]   = a;
      req_b[id*33 +: 33]   = b;
      req_c[id*66 +: 66]   = c;
      req_mode[id*2 +: 2]  = mode;
      req_shamt[id*2 +: 2] = shamt;
      req_acc[id]          = acc;
      req_shdir[id]        = dir;
   endtask

   task automatic wait_hs(input int h0, input string name);
      bit ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         if (hs_cnt > h0) begin ok = 1; break; end
      end
      if (!ok) fail_now(name);
   endtask

   task automatic wait_resp(input int r0, input string name);
      bit ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         if (resp_cnt > r0) begin ok = 1; break; end
      end
      if (!ok) fail_now(name);
   endtask

   task automatic do_op(input int id, input logic [1:0] mode, input logic [32:0] a, input logic [32:0] b,
                        input logic [65:0] c, input logic acc, input logic [1:0] shamt, input logic dir);
      int h0, r0;
      set_req(id, mode, a, b, c, acc, shamt, dir);
      h0 = hs_cnt; r0 = resp_cnt;
      req_valid[id] = 1'b1;
      wait_hs(h0, "handshake_timeout");
      #1 req_valid[id] = 1'b0;
      wait_resp(r0, "response_timeout");
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int s0, m0, h0, r0, base;
   bit ok;

   initial begin
      rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_c = '0;
      req_mode = '0; req_acc = '0; req_shamt = '0; req_shdir = '0; resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      do_op(0, 2'd0, 33'd3, 33'd5, 66'd7, 0, 2'd0, 0);
      chk("t1_data", last_data, 66'd22);
      chk("t1_id", last_id, 0);
      chk("t1_err", last_err, 0);
      chk("t1_latency", last_lat, 4);

      s0 = n_start;
      do_op(1, 2'd2, 33'h1_2345_6789, 33'h10, 66'd0, 0, 2'd0, 0);
      chk("t2_data", last_data, 66'h12_3456_7890);
      chk("t2_latency", last_lat, 7);
      chk("t2_start_pulses", n_start - s0, 1);

      do_op(1, 2'd1, 33'h1_0000_0003, 33'h1_0000_0002, 66'h10, 0, 2'd0, 0);
      chk("hf_data", last_data, 66'h3_0000_0016);
      chk("hf_latency", last_lat, 5);

      do_op(0, 2'd0, 33'd3, 33'd4, 66'd0, 0, 2'd0, 0);
      chk("t3a_data", last_data, 66'd12);
      m0 = n_mac;
      do_op(0, 2'd0, 33'd2, 33'd5, 66'd0, 1, 2'd0, 0);
      chk("t3b_data", last_data, 66'd22);
      chk("t3b_err", last_err, 0);
      chk("t3b_mac_cycles", n_mac - m0, 2);

      do_op(0, 2'd0, 33'd3, 33'd4, 66'd0, 0, 2'd0, 0);
      chk("t4a_data", last_data, 66'd12);
      do_op(1, 2'd0, 33'd2, 33'd5, 66'd0, 1, 2'd0, 0);
      chk("t4b_data", last_data, 66'd10);
      chk("t4b_err", last_err, 1);

      // Both requesters continuously, response buffer blocked for 3 cycles.
      set_req(0, 2'd0, 33'd2, 33'd3, 66'd0, 0, 2'd0, 0);
      set_req(1, 2'd0, 33'd4, 33'd5, 66'd1, 0, 2'd0, 0);
      h0 = hs_cnt; r0 = resp_cnt; base = hs_ids.size();
      resp_ready = 1'b0;
      req_valid  = 2'b11;
      ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (resp_valid) begin ok = 1; break; end
      end
      if (!ok) fail_now("t5_first_resp");
      repeat (3) @(posedge clk);
      #1 resp_ready = 1'b1;
      ok = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         if (hs_cnt - h0 >= 3) begin ok = 1; break; end
      end
      if (!ok) fail_now("t5_three_grants");
      #1 req_valid = 2'b00;
      wait_resp(r0 + 2, "t5_drain");
      #1;
      chk("t5_responses", resp_cnt - r0, 3);
      if (hs_ids.size() >= base + 3) begin
         chk("t5_grant0", hs_ids[base], 0);
         chk("t5_grant1", hs_ids[base+1], 1);
         chk("t5_grant2", hs_ids[base+2], 0);
      end else fail_now("t5_grant_order");

      // Reset during the second RUN cycle of a full x full operation.
      set_req(0, 2'd2, 33'h1_0000_0003, 33'd5, 66'd0, 0, 2'd0, 0);
      h0 = hs_cnt; r0 = resp_cnt;
      req_valid[0] = 1'b1;
      wait_hs(h0, "t6_handshake");
      #1 req_valid[0] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_dsp_start", dsp_start, 0);
      chk("t6_dsp_aa", dsp_aa, 0);
      chk("t6_dsp_bb", dsp_bb, 0);
      chk("t6_dsp_mode", dsp_mode, 0);
      chk("t6_dsp_cc", dsp_cc, 0);
      chk("t6_dsp_mac", dsp_mac, 0);
      chk("t6_resp_valid", resp_valid, 0);
      chk("t6_req_ready", req_ready, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("t6_no_response", resp_cnt - r0, 0);

      do_op(0, 2'd0, 33'd1, 33'd1, 66'd1, 1, 2'd0, 0);
      chk("t6_post_data", last_data, 66'd2);
      chk("t6_post_err", last_err, 1);

      do_op(1, 2'd3, 33'd7, 33'd7, 66'd7, 0, 2'd0, 0);
      chk("ill_data", last_data, 66'd0);
      chk("ill_err", last_err, 1);
      chk("ill_id", last_id, 1);
      chk("ill_latency", last_lat, 1);

      do_op(0, 2'd0, 33'd1, 33'd1, 66'd0, 1, 2'd1, 0);
      chk("shl_data", last_data, 66'd5);
      chk("shl_err", last_err, 0);
      do_op(0, 2'd0, 33'd1, 33'd1, 66'd0, 1, 2'd2, 1);
      chk("shr_data", last_data, 66'd2);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
